// File: rtl/alu16_stage.sv
// Registered Hack ALU stage: combinational f(x, y) with zr/ng flags feeding a
// two-entry (main + skid) output buffer, plus a wrapping completed-result counter.
module alu16_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      x,
  input  logic [15:0]      y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out,
  output logic             zr,
  output logic             ng,
  output logic [CNT_W-1:0] done_cnt
);

  logic        zx, nx, zy, ny, fn, no;
  logic [15:0] x1, x2, y1, y2;
  logic [15:0] and_r, sum_r, r, o;
  logic [17:0] new_entry;

  assign {zx, nx, zy, ny, fn, no} = ctrl;

  assign x1 = zx ? 16'h0000 : x;
  assign x2 = nx ? ~x1 : x1;
  assign y1 = zy ? 16'h0000 : y;
  assign y2 = ny ? ~y1 : y1;

  // Bitwise and16 gate array for the AND path.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_and16
      assign and_r[gi] = x2[gi] & y2[gi];
    end
  endgenerate

  assign sum_r = x2 + y2;
  assign r     = fn ? sum_r : and_r;
  assign o     = no ? ~r : r;

  // Stored entry layout: {o, zr, ng}.
  assign new_entry = {o, (o == 16'h0000), o[15]};

  logic             m_valid_reg, m_valid_next;
  logic [17:0]      m_data_reg,  m_data_next;
  logic             s_valid_reg, s_valid_next;
  logic [17:0]      s_data_reg,  s_data_next;
  logic [CNT_W-1:0] cnt_reg,     cnt_next;
  logic             in_xfer, out_xfer;

  assign in_ready  = ~s_valid_reg;
  assign out_valid = m_valid_reg;
  assign out       = m_data_reg[17:2];
  assign zr        = m_data_reg[1];
  assign ng        = m_data_reg[0];
  assign done_cnt  = cnt_reg;

  assign in_xfer  = in_valid & ~s_valid_reg;
  assign out_xfer = m_valid_reg & out_ready;

  always_comb begin
    m_valid_next = m_valid_reg;
    m_data_next  = m_data_reg;
    s_valid_next = s_valid_reg;
    s_data_next  = s_data_reg;
    cnt_next     = cnt_reg;
    if (out_xfer) begin
      cnt_next = cnt_reg + CNT_W'(1);
      if (s_valid_reg) begin
        m_data_next  = s_data_reg;
        s_valid_next = in_xfer;
        if (in_xfer) s_data_next = new_entry;
      end else begin
        m_valid_next = in_xfer;
        if (in_xfer) m_data_next = new_entry;
      end
    end else if (in_xfer) begin
      if (!m_valid_reg) begin
        m_valid_next = 1'b1;
        m_data_next  = new_entry;
      end else begin
        s_valid_next = 1'b1;
        s_data_next  = new_entry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_reg <= 1'b0;
      m_data_reg  <= '0;
      s_valid_reg <= 1'b0;
      s_data_reg  <= '0;
      cnt_reg     <= '0;
    end else begin
      m_valid_reg <= m_valid_next;
      m_data_reg  <= m_data_next;
      s_valid_reg <= s_valid_next;
      s_data_reg  <= s_data_next;
      cnt_reg     <= cnt_next;
    end
  end

endmodule

// File: tb/tb_alu16_stage.sv
// Randomized and directed bench for alu16_stage against a queue-based reference model.
module tb_alu16_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [5:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        zr;
  logic        ng;
  logic [15:0] done_cnt;

  logic        in_ready3;
  logic        out_valid3;
  logic [15:0] out3;
  logic        zr3;
  logic        ng3;
  logic [2:0]  done_cnt3;

  alu16_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zr(zr), .ng(ng), .done_cnt(done_cnt)
  );

  alu16_stage #(.CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid3), .out_ready(out_ready),
    .out(out3), .zr(zr3), .ng(ng3), .done_cnt(done_cnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec;
  int n_bad;
  logic [17:0] q[$];
  int cnt_mdl;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: Hack ALU evaluated as plain unsigned arithmetic; returns {o, zr, ng}.
  function automatic logic [17:0] ref_alu(input logic [15:0] a_in, input logic [15:0] b_in,
                                          input logic [5:0] c);
    int unsigned a, b, rr;
    a = c[5] ? 0 : int'(a_in);
    if (c[4]) a = 65535 - a;
    b = c[3] ? 0 : int'(b_in);
    if (c[2]) b = 65535 - b;
    rr = c[1] ? (a + b) % 65536 : (a & b);
    if (c[0]) rr = 65535 - rr;
    return {rr[15:0], rr == 0, rr >= 32768};
  endfunction

  // Called at a falling edge: check outputs, drive inputs, advance model over the next rising edge.
  task automatic cycle(input logic v, input logic [15:0] xv, input logic [15:0] yv,
                       input logic [5:0] cv, input logic rdy, output logic acc, output logic oxf);
    logic [17:0] e;
    in_valid  = v;
    x         = xv;
    y         = yv;
    ctrl      = cv;
    out_ready = rdy;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready3", in_ready3, q.size() < 2);
    chk("done_cnt", done_cnt, cnt_mdl % 65536);
    chk("done_cnt3", done_cnt3, cnt_mdl % 8);
    if (q.size() > 0) begin
      e = q[0];
      chk("out", out, e[17:2]);
      chk("zr", zr, e[1]);
      chk("ng", ng, e[0]);
      chk("out3", out3, e[17:2]);
    end
    acc = v && (q.size() < 2);
    oxf = rdy && (q.size() > 0);
    if (oxf) begin
      void'(q.pop_front());
      cnt_mdl++;
    end
    if (acc) q.push_back(ref_alu(xv, yv, cv));
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    logic a, o;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'h0, 16'h0, 6'h0, rdy, a, o);
  endtask

  task automatic op_const(input string tag, input logic [15:0] xv, input logic [15:0] yv,
                          input logic [5:0] cv, input logic [15:0] eo, input logic ezr,
                          input logic eng);
    logic a, o;
    cycle(1'b1, xv, yv, cv, 1'b1, a, o);
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_out"}, out, eo);
    chk({tag, "_zr"}, zr, ezr);
    chk({tag, "_ng"}, ng, eng);
    idle(1, 1'b1);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_done_cnt", done_cnt, 16'h0);
    chk("rst_out", out, 16'h0);
    chk("rst_zr", zr, 1'b0);
    chk("rst_ng", ng, 1'b0);
    q.delete();
    cnt_mdl = 0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    logic a, o;
    int idx, run;
    n_vec = 0; n_bad = 0; cnt_mdl = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; ctrl = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("init_out_valid", out_valid, 1'b0);
    chk("init_in_ready", in_ready, 1'b1);
    chk("init_done_cnt", done_cnt, 16'h0);

    op_const("and",   16'h1234, 16'h5678, 6'b000000, 16'h1230, 1'b0, 1'b0);
    op_const("add",   16'h1234, 16'h5678, 6'b000010, 16'h68AC, 1'b0, 1'b0);
    op_const("sub",   16'h1234, 16'h5678, 6'b010011, 16'hBBBC, 1'b0, 1'b1);
    op_const("zero",  16'h1234, 16'h5678, 6'b101010, 16'h0000, 1'b1, 1'b0);
    op_const("one",   16'h1234, 16'h5678, 6'b111111, 16'h0001, 1'b0, 1'b0);
    op_const("minus", 16'h1234, 16'h5678, 6'b111010, 16'hFFFF, 1'b0, 1'b1);
    op_const("carry", 16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0);

    // Backpressure: offer x = 1..4 with the consumer stalled.
    idx = 1;
    for (int i = 0; i < 5; i++) begin
      cycle(idx <= 4, 16'(idx), 16'h0, 6'b001100, 1'b0, a, o);
      if (a) idx++;
    end
    chk("bp_accepted", idx - 1, 2);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_hold", out, 16'h0001);
    run = 0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_nogap", out_valid, 1'b1);
      chk("bp_order", out, 16'(i + 1));
      cycle(idx <= 4, 16'(idx), 16'h0, 6'b001100, 1'b1, a, o);
      if (a) idx++;
      if (o) run++;
    end
    chk("bp_delivered", run, 4);

    // Mid-stream reset with both entries full and the consumer stalled.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'(i + 7), 16'h3, 6'b000010, 1'b0, a, o);
    chk("full_in_ready", in_ready, 1'b0);
    do_reset();

    // Full throughput.
    run = 0;
    for (int i = 0; i < 20; i++) begin
      chk("tp_in_ready", in_ready, 1'b1);
      cycle(1'b1, 16'($urandom), 16'($urandom), 6'($urandom), 1'b1, a, o);
      if (o) run++;
    end
    idle(1, 1'b1);
    run++;
    chk("tp_transfers", run, 20);
    chk("tp_done_cnt", done_cnt, 16'd20);

    // Counter wrap on the 3-bit instance.
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, 16'(i), 16'h1, 6'b000010, 1'b1, a, o);
    idle(2, 1'b1);
    chk("wrap_done_cnt3", done_cnt3, 3'd1);
    chk("wrap_done_cnt", done_cnt, 16'd9);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), 6'($urandom),
            $urandom_range(0, 9) < 6, a, o);
    idle(3, 1'b1);
    chk("final_empty", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/alu16_stage.md
# alu16_stage

Registered Hack ALU stage that sits directly downstream of the 16-bit gate library (and16, not16, add16). It accepts an operand pair plus the 6-bit Hack ALU control word over a valid/ready handshake and computes `out = f(x, y)` with the `zr`/`ng` flags. It presents the registered result to the CPU writeback over a second valid/ready handshake. A two-entry skid buffer provides full throughput under backpressure, and a wrapping counter records completed results.

## Interface
- `CNT_W`, default 16: width of the completed-transfer counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  operand/control word present.
- `in_ready`  out  1  stage can accept this cycle.
- `x`  in  16  operand x.
- `y`  in  16  operand y.
- `ctrl`  in  6  {zx, nx, zy, ny, f, no}, MSB = zx.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts this cycle.
- `out`  out  16  ALU result.
- `zr`  out  1  `out == 0`.
- `ng`  out  1  `out[15]`.
- `done_cnt`  out  CNT_W  number of output transfers, modulo 2^CNT_W.

## Operation
- Datapath, combinational from inputs, in this order:
  - `x1 = zx ? 0 : x`, then `x2 = nx ? ~x1 : x1`.
  - `y1 = zy ? 0 : y`, then `y2 = ny ? ~y1 : y1`.
  - `r = f ? (x2 + y2) mod 2^16 : (x2 & y2)`. The AND path is built from and16; carry-out is discarded.
  - `o = no ? ~r : r`.
- `zr` and `ng` are computed from `o` and stored with it. A stored entry is {o, zr, ng}.
- Storage: a main register (M, drives the outputs) and a skid register (S), each with a valid bit.
- `in_ready = !S.valid`, driven from a register only.
- Input transfer = `in_valid & in_ready`. Output transfer = `out_valid & out_ready`.
- Per clock edge:
  - Output transfer and S valid: M <= S and S empties. An input transfer in the same cycle loads S.
  - Output transfer and S empty: M <= new entry if an input transfer occurs; otherwise M empties.
  - No output transfer and M empty: an input transfer loads M.
  - No output transfer and M valid: an input transfer loads S.
- `done_cnt` increments by 1 on every output transfer and wraps from 2^CNT_W−1 to 0.
- Entries leave in acceptance order. No entry is dropped or duplicated.
- `x`, `y` and `ctrl` are ignored whenever no input transfer occurs.

## Timing
- Reset (asynchronous on `rst_n` low, released synchronously to `clk`):
  - `out_valid = 0`, `out = 0`, `zr = 0`, `ng = 0`, `done_cnt = 0`.
  - S empty, so `in_ready = 1`.
- Latency: an input accepted at edge N with M empty gives `out_valid = 1` with the result after edge N.
- Throughput: one result per cycle while `out_ready` stays high.
- Full: M and S both valid gives `in_ready = 0` from the next cycle. `in_ready` returns to 1 the cycle after the first output transfer.
- Outputs are stable while `out_valid & !out_ready`: `out`, `zr` and `ng` must not change.
- Simultaneous input and output transfer with S empty: M is replaced, so there is no bubble.
- Reset asserted mid-operation: all entries are discarded immediately. The counter clears. There is no partial completion.

## Test plan
- Reset check: assert `rst_n` low mid-stream, with M and S full and `out_ready = 0` → `out_valid` drops to 0 asynchronously, `done_cnt = 0`, and `in_ready = 1` after release.
- Single op: `x = 16'h1234`, `y = 16'h5678`, `out_ready = 1`. Then:
  - `ctrl = 6'b000000` → `out = 16'h1230`, `zr = 0`, `ng = 0` one cycle after acceptance.
  - `ctrl = 6'b000010` → `out = 16'h68AC`.
  - `ctrl = 6'b010011` (x−y) → `out = 16'hBBBC`, `ng = 1`.
- Constants and flags:
  - `ctrl = 6'b101010` → `out = 0`, `zr = 1`.
  - `ctrl = 6'b111111` → `out = 1`.
  - `ctrl = 6'b111010` → `out = 16'hFFFF`, `ng = 1`.
  - `x = 16'hFFFF`, `y = 1`, `ctrl = 6'b000010` → `out = 0`, `zr = 1` (carry discarded).
- Backpressure: stream 4 ops (x = 1..4, y = 0, `ctrl = 6'b001100`) with `out_ready = 0`:
  - 2 are accepted and `in_ready = 0`.
  - `out` holds 1 across stalled cycles.
  - Raising `out_ready` delivers 1, 2, 3, 4 in order with no gaps once streaming resumes.
- Full throughput: 20 back-to-back ops with `out_ready = 1` → 20 consecutive output transfers, `done_cnt = 20`, and `in_ready` never drops.
- Counter wrap: `CNT_W = 3`, 9 output transfers → `done_cnt = 1`.
